cmd_source_arbiter: RTL and testbench
=====================================

// Module: cmd_source_arbiter
// PURPOSE
// - Shares the single command byte stream into CommandInput between NUM_SRC host links (e.g. SPI, UART).
// - Round-robin grant at command boundaries; grant held for exactly one whole command, with the
//   byte count decoded from the opcode, so commands from different sources never interleave.
// - Sits between link receivers and CommandInput.cmd_s_*.
// PARAMETERS
// - NUM_SRC          2    number of byte-stream sources (>=2)
// - LEN_UPLOAD_TRI   37   total bytes incl. opcode for 0xA1 (top sets 1+$bits(cmd_triangle_t)/8)
// - LEN_ADD_INST     50   total bytes for 0xB0 (top sets 1+$bits(cmd_scene_t)/8)
// - LEN_SET_CAMERA   49   total bytes for 0xC0 (top sets 1+$bits(cmd_camera_transform_t)/8)
// - TIMEOUT_CYCLES   1024 stall limit inside a command (used only with CMD_ARB_TIMEOUT_EN)
// PORTS
// - clk          in   1             system clock
// - rstn         in   1             asynchronous active-low reset
// - src_valid    in   NUM_SRC       per-source byte valid
// - src_ready    out  NUM_SRC       per-source byte ready
// - src_data     in   NUM_SRC*8     per-source byte, source i at [8*i+:8]
// - cmd_m_valid  out  1             byte valid to CommandInput
// - cmd_m_ready  in   1             CommandInput ready
// - cmd_m_data   out  8             byte to CommandInput
// - grant_idx    out  clog2(NUM_SRC) current/last granted source
// - busy         out  1             high while a command is in flight (state != IDLE)
// - timeout_err  out  1             one-cycle pulse on watchdog abort
// BEHAVIOUR
// - Reset: state IDLE, grant_idx 0, rr pointer so source 0 has top priority, bytes_left 0,
//   src_ready 0, cmd_m_valid 0, cmd_m_data 0, busy 0, timeout_err 0.
// - Transfer = valid && ready on the respective side; data path is combinational mux on grant_idx.
// - IDLE: src_ready all 0, cmd_m_valid 0. If any src_valid: register grant_idx = first requester
//   at or after (last grant+1) mod NUM_SRC (after reset: from 0), go HEAD. One bubble cycle per command.
// - HEAD/BODY: cmd_m_valid = src_valid[grant]; cmd_m_data = src_data[grant];
//   src_ready[grant] = cmd_m_ready; all other src_ready 0.
// - HEAD transfer: len = 0x55->2, 0xA0->2, 0xA1->LEN_UPLOAD_TRI, 0xB0->LEN_ADD_INST,
//   0xC0->LEN_SET_CAMERA, other->1. len==1 -> IDLE; else bytes_left = len-1, go BODY.
// - BODY transfer: bytes_left -= 1; transfer with bytes_left==1 -> IDLE next cycle.
// - bytes_left is 8 bit; all LEN_* must be 1..255 (elaboration assertion).
// - Backpressure (cmd_m_ready 0): src_ready 0, no state/count change; source must hold data.
// - Non-granted sources wait; never dropped. Simultaneous requests resolved by rr pointer only.
// - Reset mid-command: immediate return to reset values; partial command is not completed.
// CONFIGURATION
// - CMD_ARB_TIMEOUT_EN defined: in BODY, a counter counts cycles with src_valid[grant]==0, clears
//   on any transfer. At TIMEOUT_CYCLES: timeout_err pulses 1 cycle, state PAD. PAD: src_ready all 0,
//   cmd_m_valid 1, cmd_m_data 0x00, decrement bytes_left per accepted byte; last -> IDLE. Keeps
//   CommandInput byte count in sync. Counter 0 at reset; HEAD never times out.
// - Not defined: no PAD state, BODY waits indefinitely, timeout_err tied 0, TIMEOUT_CYCLES unused.
// TESTING
// - Src0 sends 0x55,0x55, cmd_m_ready=1 -> same bytes on cmd_m, grant_idx 0, busy 1 for 2 transfers, then IDLE.
// - Both sources valid after reset: src0 0xA1+36 bytes, src1 0xC0+48 bytes -> all 37 src0 bytes
//   first, 1 idle cycle, then all 49 src1 bytes; no interleave.
// - cmd_m_ready low 5 cycles mid-BODY -> src_ready[grant] 0, cmd_m_data stable, bytes_left unchanged.
// - Src1 sends 0x12 (unknown) while src0 idle -> 1-byte command, IDLE; next request from src0 wins.
// - TIMEOUT_EN, TIMEOUT_CYCLES=16: src1 stops after 3 bytes of 0xB0 -> after 16 cycles timeout_err
//   pulse, 47 bytes 0x00 emitted, IDLE, src0 then granted.
// - rstn low in BODY -> all outputs reset values asynchronously; fresh command after release forwarded.

Source files
------------

// File: rtl/cmd_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmd_source_arbiter
// Purpose  : Round-robin arbiter merging NUM_SRC host byte streams into one
//            command stream; a grant always covers exactly one whole command.
// Options  : CMD_ARB_TIMEOUT_EN - watchdog that zero-pads a stalled command
// Revision : 1.0 - initial release
// ============================================================================
module cmd_source_arbiter #(
  parameter int NUM_SRC        = 2,
  parameter int LEN_UPLOAD_TRI = 37,
  parameter int LEN_ADD_INST   = 50,
  parameter int LEN_SET_CAMERA = 49,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC*8-1:0]       src_data,
  output logic                       cmd_m_valid,
  input  logic                       cmd_m_ready,
  output logic [7:0]                 cmd_m_data,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int c_idx_w = $clog2(NUM_SRC);

  localparam logic [7:0] c_op_two_a = 8'h55;
  localparam logic [7:0] c_op_two_b = 8'hA0;
  localparam logic [7:0] c_op_tri   = 8'hA1;
  localparam logic [7:0] c_op_inst  = 8'hB0;
  localparam logic [7:0] c_op_cam   = 8'hC0;

  localparam logic [7:0] c_len_tri  = 8'(LEN_UPLOAD_TRI);
  localparam logic [7:0] c_len_inst = 8'(LEN_ADD_INST);
  localparam logic [7:0] c_len_cam  = 8'(LEN_SET_CAMERA);

  generate
    if (NUM_SRC < 2) begin : g_chk_num_src
      $error("cmd_source_arbiter: NUM_SRC must be at least 2");
    end
    if (LEN_UPLOAD_TRI < 1 || LEN_UPLOAD_TRI > 255 ||
        LEN_ADD_INST   < 1 || LEN_ADD_INST   > 255 ||
        LEN_SET_CAMERA < 1 || LEN_SET_CAMERA > 255) begin : g_chk_len
      $error("cmd_source_arbiter: command lengths must be within 1..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
      $error("cmd_source_arbiter: TIMEOUT_CYCLES must be positive");
    end
  endgenerate

`ifdef CMD_ARB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_PAD  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_t;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_grant;
  logic [c_idx_w-1:0]   w_grant_nxt;
  logic [c_idx_w-1:0]   r_rr;
  logic [c_idx_w-1:0]   w_rr_nxt;
  logic [7:0]           r_left;
  logic [7:0]           w_left_nxt;

  logic [7:0]           w_src_byte [NUM_SRC];
  logic [c_idx_w-1:0]   w_cand     [NUM_SRC];
  logic [c_idx_w-1:0]   w_pick;
  logic [c_idx_w-1:0]   w_pick_nxt;
  logic                 w_sel_valid;
  logic [7:0]           w_sel_data;
  logic                 w_xfer;
  logic [7:0]           w_len;

`ifdef CMD_ARB_TIMEOUT_EN
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_terr;
  logic                 w_terr_nxt;
`endif

  function automatic logic [7:0] f_cmd_len(input logic [7:0] op);
    case (op)
      c_op_two_a, c_op_two_b: f_cmd_len = 8'd2;
      c_op_tri:               f_cmd_len = c_len_tri;
      c_op_inst:              f_cmd_len = c_len_inst;
      c_op_cam:               f_cmd_len = c_len_cam;
      default:                f_cmd_len = 8'd1;
    endcase
  endfunction

  // w_cand[k] is the k-th source in priority order, starting at the rr pointer
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_src_byte[g] = src_data[8*g +: 8];
    assign w_cand[g]     = c_idx_w'((int'(r_rr) + g) % NUM_SRC);
  end

  always_comb begin
    w_pick = r_rr;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[w_cand[i]]) w_pick = w_cand[i];
    end
  end

  assign w_pick_nxt  = (w_pick == c_idx_w'(NUM_SRC - 1)) ? '0 : w_pick + c_idx_w'(1);
  assign w_sel_valid = src_valid[r_grant];
  assign w_sel_data  = w_src_byte[r_grant];
  assign w_xfer      = w_sel_valid & cmd_m_ready;
  assign w_len       = f_cmd_len(w_sel_data);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr;
    w_left_nxt  = r_left;
    src_ready   = '0;
    cmd_m_valid = 1'b0;
    cmd_m_data  = 8'h00;
`ifdef CMD_ARB_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_terr_nxt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|src_valid) begin
          w_grant_nxt = w_pick;
          w_rr_nxt    = w_pick_nxt;
          w_state_nxt = ST_HEAD;
        end
      end
      ST_HEAD: begin
        cmd_m_valid         = w_sel_valid;
        cmd_m_data          = w_sel_data;
        src_ready[r_grant]  = cmd_m_ready;
        if (w_xfer) begin
          if (w_len == 8'd1) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_left_nxt  = w_len - 8'd1;
            w_state_nxt = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        cmd_m_valid         = w_sel_valid;
        cmd_m_data          = w_sel_data;
        src_ready[r_grant]  = cmd_m_ready;
        if (w_xfer) begin
          w_left_nxt = r_left - 8'd1;
          if (r_left == 8'd1) w_state_nxt = ST_IDLE;
`ifdef CMD_ARB_TIMEOUT_EN
          w_cnt_nxt = '0;
        end else if (!w_sel_valid) begin
          if (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
            w_cnt_nxt   = '0;
            w_terr_nxt  = 1'b1;
            w_state_nxt = ST_PAD;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
`endif
        end
      end
`ifdef CMD_ARB_TIMEOUT_EN
      // Filler keeps the downstream byte count aligned after an abandoned command
      ST_PAD: begin
        cmd_m_valid = 1'b1;
        if (cmd_m_ready) begin
          w_left_nxt = r_left - 8'd1;
          if (r_left == 8'd1) w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant <= '0;
      r_rr    <= '0;
      r_left  <= 8'd0;
    end else begin
      r_grant <= w_grant_nxt;
      r_rr    <= w_rr_nxt;
      r_left  <= w_left_nxt;
    end
  end

`ifdef CMD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_terr <= w_terr_nxt;
    end
  end

  assign timeout_err = r_terr;
`else
  assign timeout_err = 1'b0;
`endif

  assign grant_idx = r_grant;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cmd_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_source_arbiter
// Purpose  : Directed self-checking bench for cmd_source_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cmd_source_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  src_valid = 2'b00;
  logic [1:0]  src_ready;
  logic [15:0] src_data = 16'h0000;
  logic        cmd_m_valid;
  logic        cmd_m_ready = 1'b1;
  logic [7:0]  cmd_m_data;
  logic [0:0]  grant_idx;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] out_q[$];
  logic [0:0] gnt_q[$];
  int         cyc_q[$];

  cmd_source_arbiter #(
    .NUM_SRC        (2),
    .LEN_UPLOAD_TRI (37),
    .LEN_ADD_INST   (50),
    .LEN_SET_CAMERA (49),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_data    (src_data),
    .cmd_m_valid (cmd_m_valid),
    .cmd_m_ready (cmd_m_ready),
    .cmd_m_data  (cmd_m_data),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive_inputs();
    src_valid[0]  = (q0.size() != 0);
    src_data[7:0] = (q0.size() != 0) ? q0[0] : 8'h00;
    src_valid[1]  = (q1.size() != 0);
    src_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  // Records handshakes seen before the edge, advances one clock, pops consumed bytes
  task automatic tick();
    logic x0, x1;
    x0 = src_valid[0] & src_ready[0];
    x1 = src_valid[1] & src_ready[1];
    if (cmd_m_valid && cmd_m_ready) begin
      out_q.push_back(cmd_m_data);
      gnt_q.push_back(grant_idx);
      cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (x0 && q0.size() != 0) void'(q0.pop_front());
    if (x1 && q1.size() != 0) void'(q1.pop_front());
    drive_inputs();
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q0.delete();
    q1.delete();
    drive_inputs();
    cmd_m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    out_q.delete();
    gnt_q.delete();
    cyc_q.delete();
    cyc = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (grant_idx !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0", grant_idx); end
    n_checks++; if (src_ready !== 2'b00) begin n_fail++; $display("FAIL reset_src_ready: got %b expected 00", src_ready); end
    n_checks++; if (cmd_m_valid !== 1'b0 || cmd_m_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_cmd_m: got valid=%b data=%h expected 0/00", cmd_m_valid, cmd_m_data);
    end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
  endtask

  task automatic test_two_byte();
    do_reset();
    q0.push_back(8'h55); q0.push_back(8'h55);
    drive_inputs(); #1;
    n_checks++; if (busy !== 1'b0 || src_ready !== 2'b00 || cmd_m_valid !== 1'b0) begin
      n_fail++; $display("FAIL two_idle_bubble: got busy=%b rdy=%b v=%b expected 0/00/0", busy, src_ready, cmd_m_valid);
    end
    tick();
    n_checks++; if (busy !== 1'b1 || grant_idx !== 1'b0 || src_ready !== 2'b01) begin
      n_fail++; $display("FAIL two_head: got busy=%b grant=%b rdy=%b expected 1/0/01", busy, grant_idx, src_ready);
    end
    n_checks++; if (cmd_m_valid !== 1'b1 || cmd_m_data !== 8'h55) begin
      n_fail++; $display("FAIL two_head_data: got v=%b d=%h expected 1/55", cmd_m_valid, cmd_m_data);
    end
    tick();
    n_checks++; if (busy !== 1'b1 || cmd_m_data !== 8'h55) begin
      n_fail++; $display("FAIL two_body: got busy=%b d=%h expected 1/55", busy, cmd_m_data);
    end
    tick();
    n_checks++; if (busy !== 1'b0 || cmd_m_valid !== 1'b0) begin
      n_fail++; $display("FAIL two_done: got busy=%b v=%b expected 0/0", busy, cmd_m_valid);
    end
    n_checks++; if (out_q.size() != 2 || out_q[0] !== 8'h55 || out_q[1] !== 8'h55) begin
      n_fail++; $display("FAIL two_stream: got %0d bytes expected 2 bytes of 55", out_q.size());
    end
  endtask

  task automatic test_both_sources();
    logic [7:0] e0[$];
    logic [7:0] e1[$];
    do_reset();
    e0.push_back(8'hA1);
    for (int i = 1; i <= 36; i++) e0.push_back(8'(i));
    e1.push_back(8'hC0);
    for (int i = 1; i <= 48; i++) e1.push_back(8'(8'h80 + i));
    q0 = e0; q1 = e1;
    drive_inputs(); #1;
    for (int k = 0; k < 300 && !(q0.size() == 0 && q1.size() == 0 && busy == 1'b0); k++) tick();
    n_checks++; if (q0.size() != 0 || q1.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL both_complete: got q0=%0d q1=%0d busy=%b expected 0/0/0", q0.size(), q1.size(), busy);
    end
    n_checks++; if (out_q.size() != 86) begin
      n_fail++; $display("FAIL both_count: got %0d expected 86", out_q.size());
    end else begin
      for (int i = 0; i < 37; i++) begin
        n_checks++; if (out_q[i] !== e0[i] || gnt_q[i] !== 1'b0) begin
          n_fail++; $display("FAIL both_src0[%0d]: got %h/g%b expected %h/g0", i, out_q[i], gnt_q[i], e0[i]);
        end
      end
      for (int i = 0; i < 49; i++) begin
        n_checks++; if (out_q[37+i] !== e1[i] || gnt_q[37+i] !== 1'b1) begin
          n_fail++; $display("FAIL both_src1[%0d]: got %h/g%b expected %h/g1", i, out_q[37+i], gnt_q[37+i], e1[i]);
        end
      end
      n_checks++; if (cyc_q[37] - cyc_q[36] != 2) begin
        n_fail++; $display("FAIL both_bubble: got gap %0d expected 2", cyc_q[37] - cyc_q[36]);
      end
      n_checks++; if (cyc_q[36] - cyc_q[0] != 36 || cyc_q[85] - cyc_q[37] != 48) begin
        n_fail++; $display("FAIL both_contiguous: got spans %0d/%0d expected 36/48",
                           cyc_q[36] - cyc_q[0], cyc_q[85] - cyc_q[37]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e[$];
    do_reset();
    e.push_back(8'hB0);
    for (int i = 1; i <= 49; i++) e.push_back(8'(i * 3));
    q0 = e;
    drive_inputs(); #1;
    for (int k = 0; k < 20 && out_q.size() < 4; k++) tick();
    n_checks++; if (out_q.size() != 4) begin
      n_fail++; $display("FAIL bp_prefix: got %0d bytes expected 4", out_q.size());
    end
    cmd_m_ready = 1'b0; #1;
    for (int s = 0; s < 5; s++) begin
      tick();
      n_checks++; if (src_ready !== 2'b00 || cmd_m_valid !== 1'b1 || cmd_m_data !== e[4] || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_stall[%0d]: got rdy=%b v=%b d=%h busy=%b expected 00/1/%h/1",
                           s, src_ready, cmd_m_valid, cmd_m_data, busy, e[4]);
      end
    end
    n_checks++; if (out_q.size() != 4) begin
      n_fail++; $display("FAIL bp_no_xfer: got %0d bytes expected 4", out_q.size());
    end
    cmd_m_ready = 1'b1; #1;
    for (int k = 0; k < 100 && busy == 1'b1; k++) tick();
    n_checks++; if (busy !== 1'b0 || q0.size() != 0 || out_q.size() != 50) begin
      n_fail++; $display("FAIL bp_length: got busy=%b left=%0d out=%0d expected 0/0/50", busy, q0.size(), out_q.size());
    end else begin
      for (int i = 0; i < 50; i++) begin
        n_checks++; if (out_q[i] !== e[i]) begin
          n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, out_q[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_unknown_opcode();
    do_reset();
    q1.push_back(8'h12);
    drive_inputs(); #1;
    tick();
    n_checks++; if (grant_idx !== 1'b1 || src_ready !== 2'b10 || cmd_m_data !== 8'h12) begin
      n_fail++; $display("FAIL unk_head: got g=%b rdy=%b d=%h expected 1/10/12", grant_idx, src_ready, cmd_m_data);
    end
    tick();
    n_checks++; if (busy !== 1'b0 || out_q.size() != 1) begin
      n_fail++; $display("FAIL unk_single: got busy=%b out=%0d expected 0/1", busy, out_q.size());
    end
    q0.push_back(8'h55); q0.push_back(8'h55);
    q1.push_back(8'h20);
    drive_inputs(); #1;
    for (int k = 0; k < 30 && !(q0.size() == 0 && q1.size() == 0 && busy == 1'b0); k++) tick();
    n_checks++; if (out_q.size() != 4) begin
      n_fail++; $display("FAIL unk_count: got %0d expected 4", out_q.size());
    end else begin
      n_checks++; if (out_q[1] !== 8'h55 || out_q[2] !== 8'h55 || out_q[3] !== 8'h20) begin
        n_fail++; $display("FAIL unk_order: got %h %h %h expected 55 55 20", out_q[1], out_q[2], out_q[3]);
      end
      n_checks++; if (gnt_q[1] !== 1'b0 || gnt_q[2] !== 1'b0 || gnt_q[3] !== 1'b1) begin
        n_fail++; $display("FAIL unk_rr: got %b%b%b expected 001", gnt_q[1], gnt_q[2], gnt_q[3]);
      end
    end
  endtask

`ifdef CMD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    q1.push_back(8'hB0); q1.push_back(8'h01); q1.push_back(8'h02);
    drive_inputs(); #1;
    for (int k = 0; k < 20 && q1.size() != 0; k++) tick();
    n_checks++; if (out_q.size() != 3) begin
      n_fail++; $display("FAIL to_prefix: got %0d expected 3", out_q.size());
    end
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin tick(); n++; end
    n_checks++; if (n != 16) begin
      n_fail++; $display("FAIL to_delay: got %0d cycles expected 16", n);
    end
    n_checks++; if (cmd_m_valid !== 1'b1 || cmd_m_data !== 8'h00 || busy !== 1'b1) begin
      n_fail++; $display("FAIL to_pad: got v=%b d=%h busy=%b expected 1/00/1", cmd_m_valid, cmd_m_data, busy);
    end
    q0.push_back(8'h55); q0.push_back(8'h55);
    drive_inputs(); #1;
    n_checks++; if (src_ready !== 2'b00) begin
      n_fail++; $display("FAIL to_pad_ready: got %b expected 00", src_ready);
    end
    tick();
    n_checks++; if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse: got %b expected 0", timeout_err);
    end
    for (int k = 0; k < 100 && busy == 1'b1; k++) tick();
    n_checks++; if (out_q.size() != 50) begin
      n_fail++; $display("FAIL to_pad_count: got %0d expected 50", out_q.size());
    end else begin
      n = 0;
      for (int i = 3; i < 50; i++) if (out_q[i] !== 8'h00) n++;
      n_checks++; if (n != 0) begin
        n_fail++; $display("FAIL to_pad_zero: got %0d nonzero bytes expected 0", n);
      end
    end
    for (int k = 0; k < 20 && !(q0.size() == 0 && busy == 1'b0); k++) tick();
    n_checks++; if (out_q.size() != 52 || gnt_q[50] !== 1'b0 || out_q[50] !== 8'h55) begin
      n_fail++; $display("FAIL to_next_grant: got out=%0d expected 52 with src0 0x55", out_q.size());
    end
  endtask
`else
  task automatic test_timeout();
    logic seen;
    do_reset();
    q1.push_back(8'hB0); q1.push_back(8'h01); q1.push_back(8'h02);
    drive_inputs(); #1;
    for (int k = 0; k < 20 && q1.size() != 0; k++) tick();
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (timeout_err === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin
      n_fail++; $display("FAIL nto_err: got pulse expected none");
    end
    n_checks++; if (busy !== 1'b1 || cmd_m_valid !== 1'b0 || out_q.size() != 3) begin
      n_fail++; $display("FAIL nto_wait: got busy=%b v=%b out=%0d expected 1/0/3", busy, cmd_m_valid, out_q.size());
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    q0.push_back(8'hA1);
    for (int i = 1; i <= 36; i++) q0.push_back(8'(i));
    drive_inputs(); #1;
    for (int k = 0; k < 20 && out_q.size() < 5; k++) tick();
    n_checks++; if (busy !== 1'b1) begin
      n_fail++; $display("FAIL ar_in_body: got busy=%b expected 1", busy);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || cmd_m_valid !== 1'b0 || src_ready !== 2'b00 ||
                    grant_idx !== 1'b0 || cmd_m_data !== 8'h00 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL ar_async: got busy=%b v=%b rdy=%b g=%b d=%h te=%b expected all 0",
                         busy, cmd_m_valid, src_ready, grant_idx, cmd_m_data, timeout_err);
    end
    q0.delete();
    q1.push_back(8'h55); q1.push_back(8'h77);
    drive_inputs();
    @(posedge clk);
    #1 rstn = 1'b1;
    out_q.delete(); gnt_q.delete(); cyc_q.delete();
    #1;
    for (int k = 0; k < 20 && !(q1.size() == 0 && busy == 1'b0); k++) tick();
    n_checks++; if (out_q.size() != 2 || out_q[0] !== 8'h55 || out_q[1] !== 8'h77 || gnt_q[0] !== 1'b1) begin
      n_fail++; $display("FAIL ar_fresh: got out=%0d expected 55 77 from src1", out_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_both_sources();
    test_backpressure();
    test_unknown_opcode();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
